dmem_access_ctrl: RTL and testbench
===================================

// Module: dmem_access_ctrl
// PURPOSE
//  Multi-cycle sequencer between the CPU execute stage and a variable-latency data memory bus.
//  Takes one load/store request with the decoder's 4-bit dmem_access code and issues one word-aligned bus transaction.
//  Stalls the core until the transaction completes, then returns sign/zero-extended load data.
//  Detects misaligned addresses, illegal access codes and bus timeouts.
// PARAMETERS
//  TIMEOUT_CYCLES  64  bus_req cycles without bus_ack before abort (>=2)
//  CNT_W           7   width of timeout counter (must hold TIMEOUT_CYCLES)
// PORTS
//  clk          in   1   clock, rising edge
//  rstn         in   1   asynchronous active-low reset
//  core_req     in   1   access request; core holds it stable until core_done
//  dmem_access  in   4   0000 ld.b, 0001 ld.h, 0010 ld.w, 0100 st.b, 0101 st.h, 0110 st.w, 1000 ld.bu, 1001 ld.hu
//  core_addr    in   32  byte address (ALU result)
//  core_wdata   in   32  store data; low byte/half/word used
//  core_stall   out  1   freeze PC and pipeline
//  core_done    out  1   one-cycle completion pulse
//  core_rdata   out  32  extended load data, valid while core_done=1
//  core_err     out  1   valid with core_done: 1 = misaligned, illegal code, or timeout
//  bus_req      out  1   bus request, held until bus_ack
//  bus_we       out  1   1 = write
//  bus_addr     out  32  {core_addr[31:2],2'b00}
//  bus_wstrb    out  4   byte-lane enables, 0000 for reads
//  bus_wdata    out  32  store data replicated to the addressed lane(s)
//  bus_ack      in   1   transaction complete; bus_rdata valid in the same cycle
//  bus_rdata    in   32  read word
// BEHAVIOUR
//  Reset (async, rstn=0): state=IDLE; counter=0; all outputs 0. Reset mid-transaction drops bus_req immediately; the transaction is abandoned.
//  FSM IDLE -> BUSY -> DONE -> IDLE. bus_* outputs, core_done, core_rdata and core_err are registered.
//  IDLE with core_req=1:
//    - Latch code, address and data.
//    - Illegal code or misalignment (half with addr[0]=1, word with addr[1:0]!=0): go to DONE with err=1. No bus_req is issued.
//    - Otherwise go to BUSY. bus_req=1 from the next cycle.
//  BUSY: bus_req, bus_we, bus_addr, bus_wstrb and bus_wdata are held constant. Counter increments each cycle.
//    - bus_ack=1: capture bus_rdata, go to DONE with err=0.
//    - Counter reaches TIMEOUT_CYCLES-1 without ack: drop bus_req, go to DONE with err=1, rdata=0.
//    - A same-cycle ack wins over timeout.
//  DONE: lasts exactly one cycle. core_done=1; core_rdata and core_err are valid. Then return to IDLE; counter clears.
//  core_stall = core_req & ~core_done (combinational). A back-to-back request is sampled in the IDLE cycle after DONE.
//  Minimum latency is 3 cycles: req@T0, bus_req@T1, ack@T1, done@T2.
//  Misaligned or illegal requests complete in 2 cycles.
//  Write lanes (a = addr[1:0]):
//    - byte: wstrb = 1<<a, wdata = {4{b}}.
//    - half: wstrb = a[1] ? 1100 : 0011, wdata = {2{h}}.
//    - word: wstrb = 1111.
//  Read extraction: select the byte/half by a. ld.b/ld.h sign-extend; ld.bu/ld.hu zero-extend.
//  core_req dropping while BUSY (flush): the transaction still completes and core_done still pulses; the core ignores it.
//  Unused code bit patterns (0011, 0111, 1010..1111) are illegal.
//  bus_ack outside BUSY is ignored.
// TESTING
//  ld.w addr 0x100, ack after 3 cycles with rdata 0xDEADBEEF -> bus_req high 3 cycles, done, rdata 0xDEADBEEF, err 0
//  ld.b addr 0x103, rdata 0x80FF_FFFF -> rdata 0xFFFFFF80; ld.bu same -> 0x00000080
//  st.h addr 0x202, wdata 0x1234ABCD -> bus_addr 0x200, wstrb 1100, wdata 0xABCDABCD, we 1
//  ld.w addr 0x101 -> no bus_req, done on 2nd cycle, err 1
//  never ack with TIMEOUT_CYCLES=64 -> bus_req drops after 64 cycles, done with err 1 and rdata 0
//  rstn low while BUSY -> bus_req 0 asynchronously; after release a new st.b request completes normally

Source files
------------

// File: rtl/dmem_access_ctrl.sv
// Load/store sequencer between the execute stage and a variable-latency data bus.
// One request at a time: decode/align check, one word-aligned bus transaction,
// then a single-cycle completion pulse carrying extended load data or an error.
module dmem_access_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter int unsigned CNT_W          = 7
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        core_req,
    input  logic [3:0]  dmem_access,
    input  logic [31:0] core_addr,
    input  logic [31:0] core_wdata,
    output logic        core_stall,
    output logic        core_done,
    output logic [31:0] core_rdata,
    output logic        core_err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_wstrb,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [1:0]       state, state_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic [1:0]       size_q, size_d;
    logic             uns_q, uns_d;
    logic [1:0]       lane_q, lane_d;
    logic             bus_req_d, bus_we_d;
    logic [31:0]      bus_addr_d, bus_wdata_d;
    logic [3:0]       bus_wstrb_d;
    logic             core_done_d, core_err_d;
    logic [31:0]      core_rdata_d;

    logic             req_legal, req_misal;
    logic [3:0]       req_wstrb;
    logic [31:0]      req_wdata;
    logic [7:0]       rd_byte;
    logic [15:0]      rd_half;
    logic [31:0]      rd_ext;

    // Stall the pipeline while a request is outstanding and not yet completing
    assign core_stall = core_req & ~core_done;

    // Decode the incoming request: legality, alignment and write lane steering
    always_comb begin
        req_legal = (dmem_access[1:0] != 2'b11) &&
                    !(dmem_access[3] && (dmem_access[2] || dmem_access[1]));
        case (dmem_access[1:0])
            2'b00:   req_misal = 1'b0;
            2'b01:   req_misal = core_addr[0];
            default: req_misal = |core_addr[1:0];
        endcase
        req_wstrb = 4'b0000;
        req_wdata = '0;
        if (dmem_access[2]) begin
            case (dmem_access[1:0])
                2'b00: begin
                    req_wstrb = 4'b0001 << core_addr[1:0];
                    req_wdata = {4{core_wdata[7:0]}};
                end
                2'b01: begin
                    req_wstrb = core_addr[1] ? 4'b1100 : 4'b0011;
                    req_wdata = {2{core_wdata[15:0]}};
                end
                default: begin
                    req_wstrb = 4'b1111;
                    req_wdata = core_wdata;
                end
            endcase
        end
    end

    // Pick the addressed byte/half out of the read word and extend it
    always_comb begin
        case (lane_q)
            2'd0:    rd_byte = bus_rdata[7:0];
            2'd1:    rd_byte = bus_rdata[15:8];
            2'd2:    rd_byte = bus_rdata[23:16];
            default: rd_byte = bus_rdata[31:24];
        endcase
        rd_half = lane_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
        case (size_q)
            2'b00:   rd_ext = uns_q ? {24'd0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
            2'b01:   rd_ext = uns_q ? {16'd0, rd_half} : {{16{rd_half[15]}}, rd_half};
            default: rd_ext = bus_rdata;
        endcase
    end

    // Next-state and next-output logic; bus fields are re-held each BUSY cycle
    always_comb begin
        state_d      = state;
        cnt_d        = '0;
        size_d       = size_q;
        uns_d        = uns_q;
        lane_d       = lane_q;
        bus_req_d    = 1'b0;
        bus_we_d     = 1'b0;
        bus_addr_d   = '0;
        bus_wstrb_d  = '0;
        bus_wdata_d  = '0;
        core_done_d  = 1'b0;
        core_err_d   = 1'b0;
        core_rdata_d = '0;
        case (state)
            S_IDLE: begin
                if (core_req) begin
                    size_d = dmem_access[1:0];
                    uns_d  = dmem_access[3];
                    lane_d = core_addr[1:0];
                    if (!req_legal || req_misal) begin
                        state_d     = S_DONE;
                        core_done_d = 1'b1;
                        core_err_d  = 1'b1;
                    end else begin
                        state_d     = S_BUSY;
                        bus_req_d   = 1'b1;
                        bus_we_d    = dmem_access[2];
                        bus_addr_d  = {core_addr[31:2], 2'b00};
                        bus_wstrb_d = req_wstrb;
                        bus_wdata_d = req_wdata;
                    end
                end
            end
            S_BUSY: begin
                if (bus_ack) begin
                    state_d      = S_DONE;
                    core_done_d  = 1'b1;
                    core_rdata_d = rd_ext;
                end else if (cnt == CNT_LAST) begin
                    state_d     = S_DONE;
                    core_done_d = 1'b1;
                    core_err_d  = 1'b1;
                end else begin
                    cnt_d       = cnt + CNT_W'(1);
                    bus_req_d   = bus_req;
                    bus_we_d    = bus_we;
                    bus_addr_d  = bus_addr;
                    bus_wstrb_d = bus_wstrb;
                    bus_wdata_d = bus_wdata;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, counter, latched request and all registered outputs
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= S_IDLE;
            cnt        <= '0;
            size_q     <= '0;
            uns_q      <= 1'b0;
            lane_q     <= '0;
            bus_req    <= 1'b0;
            bus_we     <= 1'b0;
            bus_addr   <= '0;
            bus_wstrb  <= '0;
            bus_wdata  <= '0;
            core_done  <= 1'b0;
            core_err   <= 1'b0;
            core_rdata <= '0;
        end else begin
            state      <= state_d;
            cnt        <= cnt_d;
            size_q     <= size_d;
            uns_q      <= uns_d;
            lane_q     <= lane_d;
            bus_req    <= bus_req_d;
            bus_we     <= bus_we_d;
            bus_addr   <= bus_addr_d;
            bus_wstrb  <= bus_wstrb_d;
            bus_wdata  <= bus_wdata_d;
            core_done  <= core_done_d;
            core_err   <= core_err_d;
            core_rdata <= core_rdata_d;
        end
    end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Scoreboard bench for dmem_access_ctrl: the driver pushes expected completions
// and bus transactions from a reference model; a bus responder and a completion
// monitor pop and compare independently.
module tb_dmem_access_ctrl;

    localparam int TO = 64;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        core_req = 1'b0;
    logic [3:0]  dmem_access = '0;
    logic [31:0] core_addr = '0;
    logic [31:0] core_wdata = '0;
    logic        core_stall, core_done, core_err;
    logic [31:0] core_rdata;
    logic        bus_req, bus_we;
    logic [31:0] bus_addr, bus_wdata;
    logic [3:0]  bus_wstrb;
    logic        bus_ack = 1'b0;
    logic [31:0] bus_rdata = '0;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        bit          chk_rdata;
        int          lat;
    } exp_done_t;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
        bit          chk_wdata;
        int          dly;
        logic [31:0] rword;
    } exp_bus_t;

    exp_done_t done_q[$];
    exp_bus_t  bus_q[$];

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int t_start = 0;
    bit aborted = 0;

    dmem_access_ctrl #(.TIMEOUT_CYCLES(TO), .CNT_W(7)) dut (
        .clk(clk), .rstn(rstn), .core_req(core_req), .dmem_access(dmem_access),
        .core_addr(core_addr), .core_wdata(core_wdata), .core_stall(core_stall),
        .core_done(core_done), .core_rdata(core_rdata), .core_err(core_err),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_wstrb(bus_wstrb), .bus_wdata(bus_wdata), .bus_ack(bus_ack),
        .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic finish_up();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    endtask

    // Reference model: what the access should do, from the access rules alone
    function automatic void model(input logic [3:0] code, input logic [31:0] addr,
                                  input logic [31:0] wdata, input logic [31:0] rword,
                                  input int dly, output exp_done_t d, output exp_bus_t b,
                                  output bit has_bus);
        bit legal, st, uns;
        int sz, off;
        logic [31:0] mask, v;
        legal = code inside {4'h0, 4'h1, 4'h2, 4'h4, 4'h5, 4'h6, 4'h8, 4'h9};
        st    = code inside {4'h4, 4'h5, 4'h6};
        uns   = code inside {4'h8, 4'h9};
        sz    = 1 << int'(code[1:0]);
        off   = int'(addr[1:0]);
        d = '{err: 1'b1, rdata: 32'd0, chk_rdata: 1'b1, lat: 1};
        b = '{addr: 32'd0, we: 1'b0, wstrb: 4'd0, wdata: 32'd0, chk_wdata: 1'b0, dly: 0, rword: 32'd0};
        has_bus = 0;
        if (!legal || (off % sz) != 0) return;
        has_bus = 1;
        b.addr  = addr & ~32'd3;
        b.we    = st;
        b.wstrb = st ? 4'(((1 << sz) - 1) << off) : 4'd0;
        b.wdata = (sz == 1) ? wdata[7:0] * 32'h01010101 :
                  (sz == 2) ? wdata[15:0] * 32'h00010001 : wdata;
        b.chk_wdata = st;
        b.dly   = dly;
        b.rword = rword;
        if (dly == 0) begin
            d.lat = TO + 1;
            return;
        end
        d.err = 1'b0;
        d.lat = dly + 1;
        if (st) begin
            d.chk_rdata = 1'b0;
        end else begin
            mask = (sz == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * sz)) - 32'd1);
            v = (rword >> (8 * off)) & mask;
            if (!uns && sz < 4 && v[8 * sz - 1]) v = v | ~mask;
            d.rdata = v;
        end
    endfunction

    // Issue one request (dly==0: bus never acks) and wait for its completion
    task automatic do_req(input logic [3:0] code, input logic [31:0] addr,
                          input logic [31:0] wdata, input int dly, input logic [31:0] rword);
        exp_done_t d;
        exp_bus_t b;
        bit hb;
        int n;
        model(code, addr, wdata, rword, dly, d, b, hb);
        done_q.push_back(d);
        if (hb) bus_q.push_back(b);
        @(negedge clk);
        core_req = 1'b1;
        dmem_access = code;
        core_addr = addr;
        core_wdata = wdata;
        t_start = cyc;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            check("core_stall", 32'(core_stall), core_done ? 32'd0 : 32'd1);
        end while (!core_done && n < 300);
        core_req = 1'b0;
        if (!core_done) begin
            check("done_wait_timeout", 32'd0, 32'd1);
            finish_up();
        end
    endtask

    // Bus responder: checks issued transactions, acks after the planned delay
    initial begin : bus_side
        bit active;
        int k;
        exp_bus_t cur;
        active = 0;
        k = 0;
        cur = '{addr: 32'd0, we: 1'b0, wstrb: 4'd0, wdata: 32'd0, chk_wdata: 1'b0, dly: 0, rword: 32'd0};
        forever begin
            @(negedge clk);
            bus_ack = 1'b0;
            bus_rdata = $urandom;
            if (bus_req) begin
                if (!active) begin
                    if (bus_q.size() == 0) begin
                        check("unexpected_bus_req", 32'd1, 32'd0);
                    end else begin
                        cur = bus_q.pop_front();
                        active = 1;
                        k = 0;
                    end
                end
                if (active) begin
                    k++;
                    check("bus_addr", bus_addr, cur.addr);
                    check("bus_we", 32'(bus_we), 32'(cur.we));
                    check("bus_wstrb", 32'(bus_wstrb), 32'(cur.wstrb));
                    if (cur.chk_wdata) check("bus_wdata", bus_wdata, cur.wdata);
                    if (cur.dly != 0 && k == cur.dly) begin
                        bus_ack = 1'b1;
                        bus_rdata = cur.rword;
                    end
                end
            end else begin
                if (active) begin
                    active = 0;
                    if (!aborted) check("bus_req_cycles", 32'(k), 32'((cur.dly == 0) ? TO : cur.dly));
                    aborted = 0;
                end
                // Stray acks while no transaction is pending must be ignored
                if ($urandom_range(0, 3) == 0) bus_ack = 1'b1;
            end
        end
    end

    // Completion monitor: pops the scoreboard on every core_done pulse
    initial begin : done_mon
        exp_done_t d;
        forever begin
            @(negedge clk);
            if (rstn && core_done) begin
                if (done_q.size() == 0) begin
                    check("unexpected_core_done", 32'd1, 32'd0);
                end else begin
                    d = done_q.pop_front();
                    check("core_err", 32'(core_err), 32'(d.err));
                    if (d.chk_rdata) check("core_rdata", core_rdata, d.rdata);
                    check("latency", 32'(cyc - t_start), 32'(d.lat));
                end
            end
        end
    end

    // Main stimulus: directed cases, random mix, reset abort
    initial begin : stim
        logic [3:0] legal_codes [8];
        logic [3:0] code;
        logic [31:0] addr;
        int dly;
        legal_codes = '{4'h0, 4'h1, 4'h2, 4'h4, 4'h5, 4'h6, 4'h8, 4'h9};

        #2;
        check("rst_bus_req", 32'(bus_req), 32'd0);
        check("rst_core_done", 32'(core_done), 32'd0);
        check("rst_core_err", 32'(core_err), 32'd0);
        check("rst_core_rdata", core_rdata, 32'd0);
        check("rst_bus_wstrb", 32'(bus_wstrb), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;

        do_req(4'h2, 32'h0000_0100, 32'h0, 3, 32'hDEAD_BEEF);
        do_req(4'h0, 32'h0000_0103, 32'h0, 1, 32'h80FF_FFFF);
        do_req(4'h8, 32'h0000_0103, 32'h0, 1, 32'h80FF_FFFF);
        do_req(4'h5, 32'h0000_0202, 32'h1234_ABCD, 2, 32'h0);
        do_req(4'h2, 32'h0000_0101, 32'h0, 1, 32'h0);
        do_req(4'h2, 32'h0000_0040, 32'h0, 0, 32'h0);
        do_req(4'hB, 32'h0000_0000, 32'h0, 1, 32'h0);
        do_req(4'h4, 32'h0000_0003, 32'h0000_00A5, 1, 32'h0);
        do_req(4'h1, 32'h0000_0002, 32'h0, 4, 32'h8001_7FFF);
        do_req(4'h9, 32'h0000_0002, 32'h0, 1, 32'h8001_7FFF);
        do_req(4'h1, 32'h0000_0001, 32'h0, 1, 32'h0);

        for (int i = 0; i < 120; i++) begin
            if ($urandom_range(0, 3) == 0) code = 4'($urandom_range(0, 15));
            else code = legal_codes[$urandom_range(0, 7)];
            addr = $urandom;
            dly = ($urandom_range(0, 15) == 0) ? 0 : int'($urandom_range(1, 6));
            do_req(code, addr, $urandom, dly, $urandom);
        end

        // Reset while BUSY abandons the transaction and drops bus_req at once
        begin
            exp_done_t dd;
            exp_bus_t bb;
            bit hb;
            model(4'h6, 32'h0000_0300, 32'h5555_AAAA, 32'h0, 0, dd, bb, hb);
            bus_q.push_back(bb);
            @(negedge clk);
            core_req = 1'b1;
            dmem_access = 4'h6;
            core_addr = 32'h0000_0300;
            core_wdata = 32'h5555_AAAA;
            repeat (4) @(negedge clk);
            check("pre_rst_bus_req", 32'(bus_req), 32'd1);
            aborted = 1;
            #1;
            rstn = 1'b0;
            core_req = 1'b0;
            #1;
            check("async_rst_bus_req", 32'(bus_req), 32'd0);
            check("async_rst_done", 32'(core_done), 32'd0);
            @(negedge clk);
            #1;
            rstn = 1'b1;
        end
        do_req(4'h4, 32'h0000_0311, 32'h0000_003C, 2, 32'h0);

        repeat (4) @(negedge clk);
        check("done_q_empty", 32'(done_q.size()), 32'd0);
        check("bus_q_empty", 32'(bus_q.size()), 32'd0);
        finish_up();
    end

    // Absolute guard against a hung run
    initial begin : watchdog
        #500000;
        check("global_timeout", 32'd0, 32'd1);
        finish_up();
    end

endmodule
